// File: rtl/led_share_arbiter.sv
// led_share_arbiter
//   Shares one active-low LED bank between NUM_REQ pattern generators. A free-running
//   counter produces the common display tick; ownership is handed out round-robin only on
//   tick cycles. Each owner keeps the bank for at least HOLD_TICKS ticks while others wait.
//   Only the owner's pattern can reach the pins. The LED output is blanked as soon as the
//   owner drops its request, even though the grant itself only moves on a tick.
//
// Ports
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset (synchronous release expected upstream)
//   req        in   per-requester level request
//   pat_data   in   requester i pattern on [i*LED_W +: LED_W], 1 = LED on
//   tick       out  one-cycle pulse every TICK_CYCLES cycles
//   grant      out  one-hot owner, all-zero when idle
//   owner_id   out  owner index, 0 when idle
//   led        out  LED pins, active-low (0 = lit)
module led_share_arbiter #(
  parameter int unsigned TICK_CYCLES = 13_500_000,
  parameter int unsigned HOLD_TICKS  = 4,
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned LED_W       = 6
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LED_W-1:0] pat_data,
  output logic                     tick,
  output logic [NUM_REQ-1:0]       grant,
  output logic [1:0]               owner_id,
  output logic [LED_W-1:0]         led
);

  localparam int unsigned CntW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned HoldW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(TICK_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);
  // Pointer starts at the last requester so that requester 0 is scanned first.
  localparam logic [1:0]       RrInit   = 2'(NUM_REQ - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StOwn  = 1'b1;

  // ---------------------------------------------------------------------------------------
  // Display tick
  // ---------------------------------------------------------------------------------------
  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic            tick_q, tick_d;

  always_comb begin
    tick_d     = (tick_cnt_q == CntLast);
    tick_cnt_d = tick_d ? '0 : tick_cnt_q + CntW'(1);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Round-robin scan
  // ---------------------------------------------------------------------------------------
  logic [0:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [LED_W-1:0] led_q, led_d;

  logic             win_found;
  logic [1:0]       win_idx;
  logic             owner_req;

  // First asserted request at rr_ptr+1, rr_ptr+2, ... wrapping. The current owner is visited
  // last, so a winner other than the owner means another requester is waiting.
  always_comb begin : scan
    int unsigned scan_idx;
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && req[scan_idx[1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[1:0];
      end
    end
  end

  assign owner_req = req[owner_q];

  // ---------------------------------------------------------------------------------------
  // Ownership FSM, advances only on tick cycles
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;

    if (tick_q) begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_d    = StOwn;
            owner_d    = win_idx;
            rr_ptr_d   = win_idx;
            hold_cnt_d = '0;
          end
        end
        StOwn: begin
          if (!owner_req) begin
            // Owner let go: hand over regardless of how long it held.
            if (win_found) begin
              owner_d    = win_idx;
              rr_ptr_d   = win_idx;
              hold_cnt_d = '0;
            end else begin
              state_d = StIdle;
              owner_d = '0;
            end
          end else if (hold_cnt_q < HoldLast) begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end else if (win_found && (win_idx != owner_q)) begin
            owner_d    = win_idx;
            rr_ptr_d   = win_idx;
            hold_cnt_d = '0;
          end
          // Otherwise the owner is alone: keep it with the hold count saturated.
        end
        default: begin
          state_d = StIdle;
          owner_d = '0;
        end
      endcase
    end
  end

  // LED path updates every cycle so blanking and pattern changes show up one cycle later.
  always_comb begin
    led_d = {LED_W{1'b1}};
    if ((state_q == StOwn) && owner_req) begin
      led_d = ~pat_data[owner_q*LED_W +: LED_W];
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      owner_q    <= '0;
      rr_ptr_q   <= RrInit;
      hold_cnt_q <= '0;
      led_q      <= {LED_W{1'b1}};
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= led_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign tick     = tick_q;
  assign grant    = (state_q == StOwn) ? (NUM_REQ'(1) << owner_q) : '0;
  assign owner_id = (state_q == StOwn) ? owner_q : 2'b00;
  assign led      = led_q;

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter
//   Drives led_share_arbiter with TICK_CYCLES=4, HOLD_TICKS=2. Inputs change on the falling
//   edge and outputs are sampled on the falling edge. A behavioural model counts cycles since
//   reset release and decides ownership from the arbitration rules using plain integers.
module tb_led_share_arbiter;

  localparam int unsigned T = 4;
  localparam int unsigned H = 2;
  localparam int unsigned N = 3;
  localparam int unsigned W = 6;

  logic            sys_clk = 1'b0;
  logic            sys_rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  pat_data;
  logic            tick;
  logic [N-1:0]    grant;
  logic [1:0]      owner_id;
  logic [W-1:0]    led;

  always #5 sys_clk = ~sys_clk;

  led_share_arbiter #(
    .TICK_CYCLES(T),
    .HOLD_TICKS (H),
    .NUM_REQ    (N),
    .LED_W      (W)
  ) u_dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .pat_data (pat_data),
    .tick     (tick),
    .grant    (grant),
    .owner_id (owner_id),
    .led      (led)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: edges since release, owner (-1 = nobody), last winner, hold count.
  int         m_cyc;
  int         m_owner;
  int         m_rr;
  int         m_hold;
  logic       m_tick;
  logic [5:0] m_led;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cyc   = 0;
    m_owner = -1;
    m_rr    = N - 1;
    m_hold  = 0;
    m_tick  = 1'b0;
    m_led   = 6'h3f;
  endtask

  task automatic model_edge();
    int nxt;
    bit arb;
    arb = (m_cyc > 0) && (m_cyc % T == 0);
    if (m_owner >= 0 && req[m_owner] == 1'b1) m_led = ~pat_data[m_owner*W +: W];
    else m_led = 6'h3f;
    if (arb) begin
      nxt = -1;
      for (int k = 1; k <= N; k++) begin
        if (nxt < 0 && req[(m_rr + k) % N] == 1'b1) nxt = (m_rr + k) % N;
      end
      if (m_owner < 0 || req[m_owner] == 1'b0) begin
        m_owner = nxt;
        if (nxt >= 0) begin
          m_rr   = nxt;
          m_hold = 0;
        end
      end else if (m_hold < H - 1) begin
        m_hold++;
      end else if (nxt != m_owner) begin
        m_owner = nxt;
        m_rr    = nxt;
        m_hold  = 0;
      end
    end
    m_cyc++;
    m_tick = (m_cyc % T == 0);
  endtask

  function automatic logic [2:0] m_grant();
    return (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
  endfunction

  function automatic logic [1:0] m_owner_id();
    return (m_owner < 0) ? 2'd0 : 2'(m_owner);
  endfunction

  // One clock: model follows the rising edge, DUT is compared on the falling edge.
  task automatic cycle();
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else model_edge();
    @(negedge sys_clk);
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_grant", 32'(grant), 32'(m_grant()));
    chk("model_owner", 32'(owner_id), 32'(m_owner_id()));
    chk("model_led", 32'(led), 32'(m_led));
  endtask

  // Asserts reset mid-cycle, checks outputs cleared at once, releases on the next falling edge.
  task automatic do_reset();
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner_id), 32'h0);
    chk("rst_led", 32'(led), 32'h3f);
    chk("rst_tick", 32'(tick), 32'h0);
    cycle();
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [2:0] req;
    logic       tk;
    logic [2:0] gnt;
    logic [1:0] own;
    logic [5:0] led;
  } vec_t;

  vec_t       vecs[14];
  logic [2:0] rr_seq[3];

  task automatic setv(input int i, input logic [2:0] r, input logic tk, input logic [2:0] g,
                      input logic [1:0] o, input logic [5:0] l);
    vecs[i].req = r;
    vecs[i].tk  = tk;
    vecs[i].gnt = g;
    vecs[i].own = o;
    vecs[i].led = l;
  endtask

  initial begin
    // Owner 0 shows 000101, then drops its request with requester 1 (110000) waiting.
    setv(0,  3'b001, 1'b0, 3'b000, 2'd0, 6'h3f);
    setv(1,  3'b001, 1'b0, 3'b000, 2'd0, 6'h3f);
    setv(2,  3'b001, 1'b0, 3'b000, 2'd0, 6'h3f);
    setv(3,  3'b001, 1'b1, 3'b000, 2'd0, 6'h3f);
    setv(4,  3'b001, 1'b0, 3'b001, 2'd0, 6'h3f);
    setv(5,  3'b001, 1'b0, 3'b001, 2'd0, 6'h3a);
    setv(6,  3'b001, 1'b0, 3'b001, 2'd0, 6'h3a);
    setv(7,  3'b001, 1'b1, 3'b001, 2'd0, 6'h3a);
    setv(8,  3'b001, 1'b0, 3'b001, 2'd0, 6'h3a);
    setv(9,  3'b010, 1'b0, 3'b001, 2'd0, 6'h3f);
    setv(10, 3'b010, 1'b0, 3'b001, 2'd0, 6'h3f);
    setv(11, 3'b010, 1'b1, 3'b001, 2'd0, 6'h3f);
    setv(12, 3'b010, 1'b0, 3'b010, 2'd1, 6'h3f);
    setv(13, 3'b010, 1'b0, 3'b010, 2'd1, 6'h0f);
    rr_seq[0] = 3'b001;
    rr_seq[1] = 3'b010;
    rr_seq[2] = 3'b100;

    sys_rst_n = 1'b1;
    req       = '0;
    pat_data  = '0;
    model_reset();
    #2;

    // Idle bank: tick every T cycles, no grant, LEDs dark.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      cycle();
      chk("idle_tick", 32'(tick), 32'((k % T) == 0));
      chk("idle_grant", 32'(grant), 32'h0);
      chk("idle_led", 32'(led), 32'h3f);
    end

    // Table: single owner, pattern pass-through, release and handover.
    do_reset();
    pat_data = {6'b000000, 6'b110000, 6'b000101};
    for (int i = 0; i < 14; i++) begin
      req = vecs[i].req;
      cycle();
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(vecs[i].tk));
      chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_owner", i), 32'(owner_id), 32'(vecs[i].own));
      chk($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
    end

    // All requesting: each owner holds for H ticks, order 0,1,2,0.
    do_reset();
    req = 3'b111;
    for (int k = 1; k <= 36; k++) begin
      cycle();
      if (k >= 5) chk($sformatf("rr_grant_k%0d", k), 32'(grant), 32'(rr_seq[((k - 5) / 8) % 3]));
    end

    // Lone owner saturates its hold; a newcomer takes over at the very next tick.
    do_reset();
    req = 3'b001;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      if (k == 21) req = 3'b011;
      if (k == 24) chk("sat_grant_before", 32'(grant), 32'b001);
      if (k == 25) begin
        chk("sat_grant_after", 32'(grant), 32'b010);
        chk("sat_owner_after", 32'(owner_id), 32'd1);
      end
    end

    // Reset while owner 1 holds, then requester 0 absent: requester 1 wins first.
    do_reset();
    req = 3'b110;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      if (k == 4) chk("rst_restart_pre", 32'(grant), 32'h0);
      if (k == 5) begin
        chk("rst_restart_grant", 32'(grant), 32'b010);
        chk("rst_restart_owner", 32'(owner_id), 32'd1);
      end
    end

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      pat_data = 18'($urandom);
      if ($urandom_range(0, 199) == 0) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
